// File: rtl/pad_bus_pkg.sv
//------------------------------------------------------------------------------
// pad_bus_pkg : shared FSM encodings, counter width and parameter limits
//               for the pad bus arbiter.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pad_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_TURN  = 2'd2
  } state_e;

  localparam int CNT_W        = 4;

  localparam int NREQ_MIN     = 2;
  localparam int NREQ_MAX     = 8;
  localparam int MAXBURST_MIN = 1;
  localparam int MAXBURST_MAX = 15;
  localparam int TURN_MIN     = 0;
  localparam int TURN_MAX     = 3;

endpackage

`default_nettype wire

// File: rtl/pad_bus_arb_rr_pick.sv
//------------------------------------------------------------------------------
// rr_pick : combinational round-robin selector; first set request at or after
//           the pointer (with wrap) wins, returned as one-hot and index.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  win_oh,
  output logic [IDX_W-1:0] win_idx
);

  always_comb begin
    int j;
    j       = 0;
    win_oh  = '0;
    win_idx = '0;
    // Walk offsets from farthest to nearest so the nearest set request wins.
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (req[IDX_W'(j)]) begin
        win_oh                = '0;
        win_oh[IDX_W'(j)]     = 1'b1;
        win_idx               = IDX_W'(j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pad_bus_arb.sv
//------------------------------------------------------------------------------
// pad_bus_arb : round-robin arbiter driving a shared tristate pad bus with
//               bounded tenures and dead cycles between owners.
//               Optional PAD_PAR output enabled by PAD_BUS_PARITY_EN.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pad_bus_arb
  import pad_bus_pkg::*;
#(
  parameter int W        = 8,
  parameter int NREQ     = 4,
  parameter int MAXBURST = 4,
  parameter int TURN     = 1
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [NREQ-1:0] REQ,
  input  logic [NREQ*W-1:0] DATA,
  output logic [NREQ-1:0] GNT,
  output logic [W-1:0]    PAD_DO,
  output logic            PAD_OE,
`ifdef PAD_BUS_PARITY_EN
  output logic            PAD_PAR,
`endif
  output logic            BUSY
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < NREQ_MIN || NREQ > NREQ_MAX || MAXBURST < MAXBURST_MIN ||
      MAXBURST > MAXBURST_MAX || TURN < TURN_MIN || TURN > TURN_MAX) begin : g_param_check
    $error("pad_bus_arb: parameter out of range");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [W-1:0]     pad_do_q, pad_do_d;
  logic             pad_oe_q, pad_oe_d;

  logic [NREQ-1:0]  pick_oh;
  logic [IDX_W-1:0] pick_idx;
  logic [W-1:0]     owner_data;
  logic             beat;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req     (REQ),
    .ptr     (ptr_q),
    .win_oh  (pick_oh),
    .win_idx (pick_idx)
  );

  // GNT is zero outside DRIVE, so this is only ever true for the owner.
  assign beat = |(gnt_q & REQ);

  always_comb begin
    owner_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (owner_q == IDX_W'(k)) owner_data = DATA[k*W +: W];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    gnt_d    = gnt_q;
    pad_oe_d = beat;
    pad_do_d = beat ? owner_data : pad_do_q;

    case (state_q)
      ST_IDLE: begin
        if (|REQ) begin
          gnt_d   = pick_oh;
          owner_d = pick_idx;
          cnt_d   = '0;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (beat) cnt_d = cnt_q + 1'b1;
        // A final beat and a dropped request both close the tenure here.
        if (!beat || cnt_q == CNT_W'(MAXBURST - 1)) begin
          gnt_d   = '0;
          cnt_d   = '0;
          ptr_d   = (owner_q == IDX_W'(NREQ - 1)) ? '0 : owner_q + 1'b1;
          state_d = (TURN > 0) ? ST_TURN : ST_IDLE;
        end
      end
      ST_TURN: begin
        if (cnt_q == CNT_W'(TURN - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        gnt_d   = '0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      owner_q  <= '0;
      gnt_q    <= '0;
      pad_do_q <= '0;
      pad_oe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      gnt_q    <= gnt_d;
      pad_do_q <= pad_do_d;
      pad_oe_q <= pad_oe_d;
    end
  end

`ifdef PAD_BUS_PARITY_EN
  logic pad_par_q, pad_par_d;

  assign pad_par_d = beat ? ^owner_data : pad_par_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) pad_par_q <= 1'b0;
    else        pad_par_q <= pad_par_d;
  end

  assign PAD_PAR = pad_par_q;
`endif

  assign GNT    = gnt_q;
  assign PAD_DO = pad_do_q;
  assign PAD_OE = pad_oe_q;
  assign BUSY   = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_pad_bus_arb.sv
//------------------------------------------------------------------------------
// tb_pad_bus_arb : directed and randomized checks of pad_bus_arb against a
//                  tenure-level reference model.
// Revision       : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pad_bus_arb;

  localparam int W        = 8;
  localparam int NREQ     = 4;
  localparam int MAXBURST = 4;
  localparam int TURN     = 1;
  localparam int DW       = NREQ * W;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic [NREQ-1:0] REQ;
  logic [DW-1:0]   DATA;
  logic [NREQ-1:0] GNT;
  logic [W-1:0]    PAD_DO;
  logic            PAD_OE;
  logic            BUSY;
`ifdef PAD_BUS_PARITY_EN
  logic            PAD_PAR;
`endif

  pad_bus_arb #(.W(W), .NREQ(NREQ), .MAXBURST(MAXBURST), .TURN(TURN)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .REQ    (REQ),
    .DATA   (DATA),
    .GNT    (GNT),
    .PAD_DO (PAD_DO),
    .PAD_OE (PAD_OE),
`ifdef PAD_BUS_PARITY_EN
    .PAD_PAR(PAD_PAR),
`endif
    .BUSY   (BUSY)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: who owns the bus, how many beats it has taken, how many
  // dead cycles remain, and whose turn is next.
  int          m_owner, m_beats, m_dead, m_ptr;
  logic        m_oe, m_par;
  logic [W-1:0] m_do;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_beats = 0; m_dead = 0; m_ptr = 0;
    m_oe = 1'b0; m_do = '0; m_par = 1'b0;
  endtask

  task automatic model_edge(input logic [NREQ-1:0] req, input logic [DW-1:0] data);
    logic [W-1:0] d;
    m_oe = 1'b0;
    if (m_owner >= 0) begin
      if (req[m_owner]) begin
        d = data[m_owner*W +: W];
        m_oe = 1'b1; m_do = d; m_par = ^d;
        m_beats++;
      end
      if (!req[m_owner] || m_beats == MAXBURST) begin
        m_ptr   = (m_owner + 1) % NREQ;
        m_owner = -1;
        m_dead  = TURN;
      end
    end else if (m_dead > 0) begin
      m_dead--;
    end else if (req != '0) begin
      for (int i = 0; i < NREQ; i++)
        if (m_owner < 0 && req[(m_ptr + i) % NREQ]) m_owner = (m_ptr + i) % NREQ;
      m_beats = 0;
    end
  endtask

  task automatic check_model();
    logic [NREQ-1:0] eg;
    eg = (m_owner >= 0) ? NREQ'(1 << m_owner) : '0;
    chk("gnt",    GNT,    eg);
    chk("pad_oe", PAD_OE, m_oe);
    chk("pad_do", PAD_DO, m_do);
    chk("busy",   BUSY,   (m_owner >= 0 || m_dead > 0));
`ifdef PAD_BUS_PARITY_EN
    chk("pad_par", PAD_PAR, m_par);
`endif
  endtask

  // Present inputs for one cycle, advance through the edge, then check.
  task automatic cycle(input logic [NREQ-1:0] req, input logic [DW-1:0] data);
    REQ = req; DATA = data;
    @(posedge CLK); #1;
    cyc++;
    model_edge(req, data);
    check_model();
  endtask

  function automatic logic [DW-1:0] rnd();
    return DW'($urandom);
  endfunction

  initial begin
    logic [DW-1:0]   dv;
    logic [NREQ-1:0] rq, last_g;
    logic            prev_oe, found;
    int              last_hi;

    RST_N = 1'b0; REQ = '1; DATA = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_gnt", GNT, 0); chk("rst_oe", PAD_OE, 0);
    chk("rst_do", PAD_DO, 0); chk("rst_busy", BUSY, 0);
    RST_N = 1'b1;

    // All requesting from reset: requester 0 first, full burst, one dead cycle.
    for (int c = 1; c <= 8; c++) begin
      dv = rnd();
      cycle(4'hF, dv);
      if (c == 1) chk("p1_first_gnt", GNT, 4'b0001);
      if (c >= 2 && c <= 5) begin
        chk("p1_oe_hi", PAD_OE, 1);
        chk("p1_do", PAD_DO, dv[7:0]);
      end
      if (c == 6 || c == 7) chk("p1_oe_gap", PAD_OE, 0);
      if (c == 7) chk("p1_next_gnt", GNT, 4'b0010);
      if (c == 8) chk("p1_oe_next", PAD_OE, 1);
    end

    // Continuous requests: strict rotation, OE-high to OE-high distance TURN+2.
    last_g = 4'b0010; last_hi = cyc; prev_oe = 1'b1;
    for (int c = 0; c < 40; c++) begin
      logic [NREQ-1:0] gprev;
      gprev = GNT;
      cycle(4'hF, rnd());
      if (GNT != '0 && gprev == '0) begin
        chk("rr_order", GNT, {last_g[NREQ-2:0], last_g[NREQ-1]});
        last_g = GNT;
      end
      if (PAD_OE && !prev_oe) chk("rr_oe_distance", cyc - last_hi, TURN + 2);
      if (PAD_OE) last_hi = cyc;
      prev_oe = PAD_OE;
    end

    // Reset in the middle of a burst drops OE and GNT without a clock edge.
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      cycle(4'hF, rnd());
      if (m_owner >= 0 && m_beats == 2) found = 1'b1;
    end
    chk("mid_found", found, 1);
    chk("mid_oe_pre", PAD_OE, 1);
    #3 RST_N = 1'b0;
    #1;
    chk("mid_rst_oe", PAD_OE, 0);
    chk("mid_rst_gnt", GNT, 0);
    @(posedge CLK); #1;
    model_reset();
    RST_N = 1'b1;
    cycle(4'hF, rnd());
    chk("mid_restart_gnt", GNT, 4'b0001);

    // Single requester, two beats then release.
    repeat (8) cycle('0, rnd());
    cycle(4'b0100, rnd());
    chk("single_gnt", GNT, 4'b0100);
    cycle(4'b0100, 32'h00A5_0000);
    chk("single_do0", PAD_DO, 8'hA5);
    cycle(4'b0100, 32'h005A_0000);
    chk("single_do1", PAD_DO, 8'h5A);
    cycle('0, rnd());
    chk("single_oe_off", PAD_OE, 0);
    chk("single_busy_turn", BUSY, 1);
    cycle('0, rnd());
    chk("single_busy_idle", BUSY, 0);

`ifdef PAD_BUS_PARITY_EN
    repeat (4) cycle('0, rnd());
    cycle(4'b0100, rnd());
    cycle(4'b0100, 32'h0003_0000);
    chk("par_03", PAD_PAR, 0);
    cycle(4'b0100, 32'h0007_0000);
    chk("par_07", PAD_PAR, 1);
    repeat (3) cycle('0, rnd());
    chk("par_hold", PAD_PAR, 1);
`endif

    // Randomized traffic with occasional quiet cycles.
    for (int c = 0; c < 600; c++) begin
      rq = NREQ'($urandom | $urandom);
      if ($urandom_range(0, 15) == 0) rq = '0;
      cycle(rq, rnd());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
